// File: rtl/uart_tx.sv
// uart_tx: serial transmitter, one frame bit per CLK cycle.
// Frame: start bit (0), DATA_WIDTH data bits LSB first, optional parity bit, stop bit (1).
// A new request is taken while idle or during the stop bit, so frames can run back-to-back.
// The parity bit and the PARITY state are built only when UART_TX_PARITY_EN is defined.
// Without that macro, PAR_EN and PAR_TYP are accepted on the ports but have no effect.
module uart_tx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic [DATA_WIDTH-1:0] P_DATA,
  input  logic                  DATA_VALID,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  output logic                  TX_OUT,
  output logic                  BUSY
);

  localparam int CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t                  state;
  logic [CNT_W-1:0]        bit_cnt;
  logic [CNT_W-1:0]        nxt_idx;
  logic [DATA_WIDTH-1:0]   data_q;
  logic                    accept;

`ifdef UART_TX_PARITY_EN
  logic                    par_en_q;
  logic                    par_typ_q;

  // Even parity is the XOR of all data bits; odd parity is its inverse.
  function automatic logic parity_bit(input logic [DATA_WIDTH-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction
`else
  logic                    unused_par_cfg;
  assign unused_par_cfg = PAR_EN ^ PAR_TYP;
`endif

  assign accept  = DATA_VALID && ((state == IDLE) || (state == STOP));
  assign nxt_idx = bit_cnt + CNT_W'(1);

  // Frame sequencer: state, bit counter, latched request and registered line/busy outputs.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state     <= IDLE;
      bit_cnt   <= '0;
      data_q    <= '0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_typ_q <= 1'b0;
`endif
      TX_OUT    <= 1'b1;
      BUSY      <= 1'b0;
    end else begin
      case (state)
        IDLE, STOP: begin
          if (accept) begin
            state     <= START;
            data_q    <= P_DATA;
`ifdef UART_TX_PARITY_EN
            par_en_q  <= PAR_EN;
            par_typ_q <= PAR_TYP;
`endif
            TX_OUT    <= 1'b0;
            BUSY      <= 1'b1;
          end else begin
            state  <= IDLE;
            TX_OUT <= 1'b1;
            BUSY   <= 1'b0;
          end
        end
        START: begin
          state   <= DATA;
          bit_cnt <= '0;
          TX_OUT  <= data_q[0];
        end
        DATA: begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state  <= PARITY;
              TX_OUT <= parity_bit(data_q, par_typ_q);
            end else begin
              state  <= STOP;
              TX_OUT <= 1'b1;
            end
`else
            state  <= STOP;
            TX_OUT <= 1'b1;
`endif
          end else begin
            bit_cnt <= nxt_idx;
            TX_OUT  <= data_q[nxt_idx];
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          state  <= STOP;
          TX_OUT <= 1'b1;
        end
`endif
        default: begin
          state   <= IDLE;
          bit_cnt <= '0;
          TX_OUT  <= 1'b1;
          BUSY    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx.sv
// tb_uart_tx: directed and randomized stimulus for uart_tx against a frame-level line model.
// The model keeps a queue of line bits still to be shown; a request is taken whenever
// that queue is empty (line idle or showing its stop bit).
module tb_uart_tx;

  localparam int W = 8;
`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILD = 1'b1;
`else
  localparam bit PAR_BUILD = 1'b0;
`endif

  logic         CLK;
  logic         RST_N;
  logic [W-1:0] P_DATA;
  logic         DATA_VALID;
  logic         PAR_EN;
  logic         PAR_TYP;
  logic         TX_OUT;
  logic         BUSY;

  int n_assert = 0;
  int n_fail   = 0;

  bit q[$];
  bit hist[$];
  logic exp_tx;
  logic exp_busy;

  uart_tx #(.DATA_WIDTH(W)) dut (
    .CLK        (CLK),
    .RST_N      (RST_N),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Drive one cycle of inputs, advance the model at the rising edge, check at the falling edge.
  task automatic step(input logic dv, input logic [W-1:0] d, input logic pe, input logic pt,
                      input string tag);
    DATA_VALID = dv;
    P_DATA     = d;
    PAR_EN     = pe;
    PAR_TYP    = pt;
    @(posedge CLK);
    if (!RST_N) begin
      q.delete();
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end else if (q.size() > 0) begin
      exp_tx   = q.pop_front();
      exp_busy = 1'b1;
    end else if (dv) begin
      exp_tx   = 1'b0;
      exp_busy = 1'b1;
      for (int i = 0; i < W; i++) q.push_back(d[i]);
      if (pe && PAR_BUILD) q.push_back((($countones(d) % 2) == 1) ^ pt);
      q.push_back(1'b1);
    end else begin
      exp_tx   = 1'b1;
      exp_busy = 1'b0;
    end
    @(negedge CLK);
    hist.push_back(TX_OUT);
    n_assert++;
    assert (TX_OUT === exp_tx) else begin
      n_fail++;
      $error("FAIL %s tx: got %b expected %b", tag, TX_OUT, exp_tx);
    end
    n_assert++;
    assert (BUSY === exp_busy) else begin
      n_fail++;
      $error("FAIL %s busy: got %b expected %b", tag, BUSY, exp_busy);
    end
  endtask

  // Send one request and compare the whole observed line sequence with a fixed pattern.
  task automatic fixed_frame(input logic [W-1:0] d, input logic pe, input logic pt,
                             input int n, input logic [10:0] exp_bits, input string tag);
    logic [10:0] act;
    hist.delete();
    step(1'b1, d, pe, pt, tag);
    for (int i = 1; i < n; i++) step(1'b0, $urandom, $urandom, $urandom, tag);
    step(1'b0, '0, 1'b0, 1'b0, tag);
    act = '1;
    for (int i = 0; i < n; i++) act[i] = hist[i];
    n_assert++;
    assert (act === exp_bits) else begin
      n_fail++;
      $error("FAIL %s frame: got %b expected %b", tag, act, exp_bits);
    end
  endtask

  initial begin
    RST_N      = 1'b0;
    DATA_VALID = 1'b0;
    P_DATA     = '0;
    PAR_EN     = 1'b0;
    PAR_TYP    = 1'b0;
    exp_tx     = 1'b1;
    exp_busy   = 1'b0;
    #12;
    n_assert++;
    assert (TX_OUT === 1'b1 && BUSY === 1'b0) else begin
      n_fail++;
      $error("FAIL reset_state: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
    end
    @(negedge CLK);
    RST_N = 1'b1;

    // Fixed frames from the requirement examples.
    fixed_frame(8'h01, 1'b0, 1'b0, 10, 11'b11000000010, "f01_nopar");
`ifdef UART_TX_PARITY_EN
    fixed_frame(8'hA5, 1'b1, 1'b0, 11, 11'b10101001010, "fA5_even");
    fixed_frame(8'hA5, 1'b1, 1'b1, 11, 11'b11101001010, "fA5_odd");
    fixed_frame(8'h07, 1'b1, 1'b0, 11, 11'b11000001110, "f07_even");
`else
    fixed_frame(8'hAA, 1'b1, 1'b0, 10, 11'b11101010100, "fAA_nopar_build");
    fixed_frame(8'hA5, 1'b1, 1'b1, 10, 11'b11101001010, "fA5_nopar_build");
`endif

    // Back-to-back: request held high, new data offered during the frame.
    step(1'b1, 8'h55, 1'b1, 1'b0, "b2b");
    for (int i = 0; i < 12; i++) step(1'b1, 8'h33, 1'b0, 1'b1, "b2b");
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "b2b_drain");

    // Single pulse during the data bits is ignored.
    step(1'b1, 8'h3C, 1'b0, 1'b0, "pulse");
    step(1'b0, 8'h00, 1'b0, 1'b0, "pulse");
    step(1'b0, 8'h00, 1'b0, 1'b0, "pulse");
    step(1'b1, 8'hFF, 1'b1, 1'b1, "pulse");
    for (int i = 0; i < 10; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "pulse_drain");

    // Asynchronous reset in the middle of data bit 3 of 0xF0.
    step(1'b1, 8'hF0, 1'b0, 1'b0, "rst_mid");
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "rst_mid");
    #1;
    RST_N = 1'b0;
    #1;
    n_assert++;
    assert (TX_OUT === 1'b1 && BUSY === 1'b0) else begin
      n_fail++;
      $error("FAIL async_reset: got tx=%b busy=%b expected tx=1 busy=0", TX_OUT, BUSY);
    end
    step(1'b1, 8'h99, 1'b1, 1'b0, "in_reset");
    RST_N = 1'b1;
    q.delete();
    step(1'b1, 8'h0F, 1'b0, 1'b0, "after_rst");
    for (int i = 0; i < 11; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "after_rst");

    // Randomized requests with input data churning every cycle.
    for (int i = 0; i < 400; i++) begin
      step(($urandom % 4) == 0, W'($urandom), 1'($urandom), 1'($urandom), "rand");
    end
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b0, 1'b0, "rand_drain");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
